// File: rtl/axi_gyro_hsi_pkg.sv
// axi_gyro_hsi_pkg: register word indices, AXI response codes and CTRL/STATUS bit positions
package axi_gyro_hsi_pkg;
    typedef enum logic [2:0] {
        REG_CTRL, REG_SCR1, REG_SCR2, REG_DEC, REG_X, REG_Y, REG_Z, REG_STATUS
    } reg_idx_e;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int ST_NEW = 16;
    localparam int ST_OVR = 17;
    localparam int CTRL_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
endpackage

// File: rtl/axi_gyro_hsi_regs_if.sv
// axi_gyro_hsi_regs_if: AXI4-Lite bus bundle; master drives addr/data/valid/ready-for-response, slave drives ready/resp/rdata
interface axi_gyro_hsi_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata, rdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic [1:0] bresp, rresp;
    modport master(
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave(
        input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_gyro_hsi_capture.sv
// axi_gyro_hsi_capture: decimated X/Y/Z capture with coherent Y/Z snapshot on X read; in clk/rst_n/enable/dec/gyro_*/snap/clr_*, out x_s/y_hold/z_hold/status
module axi_gyro_hsi_capture
    import axi_gyro_hsi_pkg::*;
#(
    parameter int C_SAMPLE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [7:0]                dec,
    input  logic                      gyro_valid,
    input  logic [C_SAMPLE_WIDTH-1:0] gyro_x,
    input  logic [C_SAMPLE_WIDTH-1:0] gyro_y,
    input  logic [C_SAMPLE_WIDTH-1:0] gyro_z,
    input  logic                      snap,
    input  logic                      clr_new,
    input  logic                      clr_ovr,
    output logic [31:0]               x_s,
    output logic [31:0]               y_hold,
    output logic [31:0]               z_hold,
    output logic [31:0]               status
);
    localparam int E = 32 - C_SAMPLE_WIDTH;
    logic [C_SAMPLE_WIDTH-1:0] x_r, y_r, z_r;
    logic [7:0] cnt;
    logic [15:0] count;
    logic new_f, ovr;
    logic cap;
    assign cap = enable & gyro_valid & (cnt == dec);
    assign x_s = {{E{x_r[C_SAMPLE_WIDTH-1]}}, x_r};
    always_comb begin
        status = '0;
        status[15:0] = count;
        status[ST_NEW] = new_f;
        status[ST_OVR] = ovr;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {x_r, y_r, z_r, cnt, count, new_f, ovr} <= '0;
            y_hold <= '0;
            z_hold <= '0;
        end else begin
            cnt <= !enable ? 8'd0 : cap ? 8'd0 : gyro_valid ? cnt + 8'd1 : cnt;
            if (cap) begin
                x_r <= gyro_x;
                y_r <= gyro_y;
                z_r <= gyro_z;
                count <= count + 16'd1;
            end
            new_f <= cap | (new_f & !clr_new);
            ovr <= (cap & new_f) | (ovr & !clr_ovr);
            if (snap) begin
                y_hold <= {{E{y_r[C_SAMPLE_WIDTH-1]}}, y_r};
                z_hold <= {{E{z_r[C_SAMPLE_WIDTH-1]}}, z_r};
            end
        end
    end
endmodule

// File: rtl/axi_gyro_hsi_regs.sv
// axi_gyro_hsi_regs: AXI4-Lite register file for gyro HSI; ports S_AXI_ACLK/S_AXI_ARESETN, s_axi slave bus, gyro_* samples in, ctrl_enable/irq out
module axi_gyro_hsi_regs
    import axi_gyro_hsi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_SAMPLE_WIDTH = 16
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    axi_gyro_hsi_regs_if.slave        s_axi,
    input  logic                      gyro_valid,
    input  logic [C_SAMPLE_WIDTH-1:0] gyro_x,
    input  logic [C_SAMPLE_WIDTH-1:0] gyro_y,
    input  logic [C_SAMPLE_WIDTH-1:0] gyro_z,
    output logic                      ctrl_enable,
    output logic                      irq
);
    logic [31:0] regs [4];
    logic [31:0] x_s, y_h, z_h, status, rmux;
    logic [2:0] wa, ra;
    logic wr, rd, aw_go;
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
    assign wa = s_axi.awaddr[4:2];
    assign ra = s_axi.araddr[4:2];
    assign wr = s_axi.awready & s_axi.awvalid & s_axi.wvalid;
    assign rd = s_axi.arready & s_axi.arvalid;
    assign aw_go = s_axi.awvalid & s_axi.wvalid & !s_axi.bvalid & !s_axi.awready;
    assign ctrl_enable = regs[0][CTRL_EN];
    assign irq = status[ST_NEW] & regs[0][CTRL_IRQ_EN];
    always_comb rmux = ra == REG_X ? x_s : ra == REG_Y ? y_h : ra == REG_Z ? z_h :
                       ra == REG_STATUS ? status : regs[ra[1:0]];
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            regs <= '{default: '0};
            {s_axi.awready, s_axi.wready, s_axi.bvalid} <= '0;
            s_axi.bresp <= RESP_OKAY;
        end else begin
            s_axi.awready <= aw_go;
            s_axi.wready <= aw_go;
            if (wr) begin
                s_axi.bvalid <= 1'b1;
                s_axi.bresp <= (wa == REG_X || wa == REG_Y || wa == REG_Z) ? RESP_SLVERR : RESP_OKAY;
                if (!wa[2])
                    for (int b = 0; b < 4; b++)
                        if (s_axi.wstrb[b]) regs[wa[1:0]][8*b+:8] <= s_axi.wdata[8*b+:8];
            end else if (s_axi.bready) s_axi.bvalid <= 1'b0;
        end
    end
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            {s_axi.arready, s_axi.rvalid} <= '0;
            s_axi.rdata <= '0;
            s_axi.rresp <= RESP_OKAY;
        end else begin
            s_axi.arready <= s_axi.arvalid & !s_axi.rvalid & !s_axi.arready;
            if (rd) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata <= rmux;
                s_axi.rresp <= RESP_OKAY;
            end else if (s_axi.rready) s_axi.rvalid <= 1'b0;
        end
    end
    axi_gyro_hsi_capture #(.C_SAMPLE_WIDTH(C_SAMPLE_WIDTH)) u_capture (
        .clk(S_AXI_ACLK),
        .rst_n(S_AXI_ARESETN),
        .enable(ctrl_enable),
        .dec(regs[3][7:0]),
        .gyro_valid(gyro_valid),
        .gyro_x(gyro_x),
        .gyro_y(gyro_y),
        .gyro_z(gyro_z),
        .snap(rd && ra == REG_X),
        .clr_new(wr && wa == REG_STATUS && s_axi.wdata[ST_NEW]),
        .clr_ovr(wr && wa == REG_STATUS && s_axi.wdata[ST_OVR]),
        .x_s(x_s),
        .y_hold(y_h),
        .z_hold(z_h),
        .status(status)
    );
endmodule

// File: tb/tb_axi_gyro_hsi_regs.sv
// tb_axi_gyro_hsi_regs: directed self-checking bench for axi_gyro_hsi_regs
module tb_axi_gyro_hsi_regs;
    logic clk = 0, rst_n = 0;
    logic gyro_valid = 0;
    logic [15:0] gyro_x = 0, gyro_y = 0, gyro_z = 0;
    logic ctrl_enable, irq;
    int checks = 0, failures = 0;
    logic [1:0] resp;
    axi_gyro_hsi_regs_if bus();
    axi_gyro_hsi_regs dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(bus.slave),
        .gyro_valid(gyro_valid),
        .gyro_x(gyro_x),
        .gyro_y(gyro_y),
        .gyro_z(gyro_z),
        .ctrl_enable(ctrl_enable),
        .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        int n = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1; bus.wvalid = 1;
        while (!bus.awready && n < 20) begin tick(); n++; end
        if (n == 20) check("wr_aw_timeout", 0, 1);
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        n = 0;
        while (!bus.bvalid && n < 20) begin tick(); n++; end
        if (n == 20) check("wr_b_timeout", 0, 1);
        r = bus.bresp;
        bus.bready = 1;
        tick();
        bus.bready = 0;
    endtask
    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1;
        while (!bus.arready && n < 20) begin tick(); n++; end
        if (n == 20) check("rd_ar_timeout", 0, 1);
        tick();
        bus.arvalid = 0;
        n = 0;
        while (!bus.rvalid && n < 20) begin tick(); n++; end
        if (n == 20) check("rd_r_timeout", 0, 1);
        d = bus.rdata;
        check("rresp", {30'd0, bus.rresp}, 0);
        bus.rready = 1;
        tick();
        bus.rready = 0;
    endtask
    task automatic wr_chk(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp);
        logic [1:0] r;
        axi_wr(a, d, s, r);
        check(tag, {30'd0, r}, {30'd0, exp});
    endtask
    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_rd(a, d);
        check(tag, d, exp);
    endtask
    task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        gyro_x = x; gyro_y = y; gyro_z = z; gyro_valid = 1;
        tick();
        gyro_valid = 0;
    endtask
    initial begin
        int n;
        {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} = '0;
        bus.awaddr = 0; bus.araddr = 0; bus.awprot = 0; bus.arprot = 0; bus.wdata = 0; bus.wstrb = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        check("rst_ctl", {25'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, irq, ctrl_enable}, 0);
        check("rst_rdata", bus.rdata, 0);
        wr_chk("bresp_w0", 5'h00, 32'h1, 4'hF, 2'b00);
        check("ctrl_enable", {31'd0, ctrl_enable}, 1);
        wr_chk("bresp_w1", 5'h04, 32'h2, 4'hF, 2'b00);
        wr_chk("bresp_w2", 5'h08, 32'h3, 4'hF, 2'b00);
        wr_chk("bresp_w3", 5'h0C, 32'h4, 4'hF, 2'b00);
        rd_chk("rd_w0", 5'h00, 32'h1);
        rd_chk("rd_w1", 5'h04, 32'h2);
        rd_chk("rd_w2", 5'h08, 32'h3);
        rd_chk("rd_w3", 5'h0C, 32'h4);
        wr_chk("bresp_full", 5'h04, 32'hAABBCCDD, 4'hF, 2'b00);
        wr_chk("bresp_strb", 5'h04, 32'h11223344, 4'h5, 2'b00);
        rd_chk("rd_strb", 5'h04, 32'hAA22CC44);
        wr_chk("bresp_ro", 5'h10, 32'hDEAD, 4'hF, 2'b10);
        rd_chk("rd_x_ro", 5'h10, 32'h0);
        wr_chk("bresp_ctrl", 5'h00, 32'h3, 4'hF, 2'b00);
        wr_chk("bresp_dec0", 5'h0C, 32'h0, 4'hF, 2'b00);
        pulse(16'h8001, 16'h0002, 16'h7FFF);
        check("irq_set", {31'd0, irq}, 1);
        rd_chk("status1", 5'h1C, 32'h00010001);
        rd_chk("rd_x_sext", 5'h10, 32'hFFFF8001);
        pulse(16'h0010, 16'h0005, 16'h1234);
        rd_chk("rd_y_coh", 5'h14, 32'h00000002);
        rd_chk("rd_z_coh", 5'h18, 32'h00007FFF);
        rd_chk("status_ovr", 5'h1C, 32'h00030002);
        wr_chk("bresp_w1c", 5'h1C, 32'h00030000, 4'hF, 2'b00);
        check("irq_clr", {31'd0, irq}, 0);
        rd_chk("status_clr", 5'h1C, 32'h00000002);
        rd_chk("rd_x2", 5'h10, 32'h00000010);
        rd_chk("rd_y2", 5'h14, 32'h00000005);
        wr_chk("bresp_dec1", 5'h0C, 32'h1, 4'hF, 2'b00);
        pulse(16'h0001, 16'h0001, 16'h0001);
        rd_chk("dec_skip", 5'h1C, 32'h00000002);
        pulse(16'h0002, 16'h0002, 16'h0002);
        rd_chk("dec_take", 5'h1C, 32'h00010003);
        wr_chk("bresp_dis", 5'h00, 32'h0, 4'hF, 2'b00);
        pulse(16'h0003, 16'h0003, 16'h0003);
        pulse(16'h0004, 16'h0004, 16'h0004);
        rd_chk("dis_hold", 5'h1C, 32'h00010003);
        check("irq_masked", {31'd0, irq}, 0);
        bus.awaddr = 5'h04; bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
        n = 0;
        while (!bus.awready && n < 20) begin tick(); n++; end
        tick();
        bus.wdata = 32'h9ABCDEF0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bhold", {28'd0, bus.bvalid, bus.bresp, bus.awready}, {28'd0, 4'b1000});
        end
        bus.bready = 1;
        tick();
        bus.bready = 0;
        check("bvalid_drop", {31'd0, bus.bvalid}, 0);
        wr_chk("bresp_second", 5'h04, 32'h9ABCDEF0, 4'hF, 2'b00);
        rd_chk("rd_second", 5'h04, 32'h9ABCDEF0);
        wr_chk("bresp_pre", 5'h00, 32'h3, 4'hF, 2'b00);
        bus.awaddr = 5'h08; bus.wdata = 32'hFF; bus.awvalid = 1; bus.wvalid = 1;
        n = 0;
        while (!bus.awready && n < 20) begin tick(); n++; end
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        check("bvalid_pre_rst", {31'd0, bus.bvalid}, 1);
        rst_n = 0;
        tick();
        check("bvalid_rst", {31'd0, bus.bvalid}, 0);
        rst_n = 1;
        tick();
        check("rst2_ctl", {30'd0, irq, ctrl_enable}, 0);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd%0d", i), 5'(i * 4), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
